// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot controller.
package evm_pkg;

    localparam int unsigned NUM_CANDIDATES = 4;
    localparam int unsigned TALLY_W        = 8;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCommit,
        StLockout
    } state_t;

    function automatic int unsigned count_ones(input logic [NUM_CANDIDATES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Multi-stage synchronizer for raw buttons plus registered rising-edge detect.
module button_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_btn_s,
    output logic [WIDTH-1:0] o_press
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_btn_q;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] w_btn_s;

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_btn_q <= '0;
            r_press <= '0;
        end else begin
            r_sync[0] <= i_btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_btn_q <= w_btn_s;
            r_press <= w_btn_s & ~r_btn_q;
        end
    end

    assign o_btn_s = w_btn_s;
    assign o_press = r_press;

endmodule

// File: rtl/ballot_controller.sv
// One-vote-per-arm ballot controller with post-vote lockout and saturating tallies.
module ballot_controller
    import evm_pkg::*;
#(
    parameter int unsigned LOCKOUT_CYCLES = 100000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      ballot_enable,
    input  logic [NUM_CANDIDATES-1:0] candidate_button,
    output logic                      armed,
    output logic                      valid_vote_casted,
    output logic [NUM_CANDIDATES-1:0] vote_onehot,
    output logic                      reject_pulse,
    output logic [TALLY_W-1:0]        candidate1_vote,
    output logic [TALLY_W-1:0]        candidate2_vote,
    output logic [TALLY_W-1:0]        candidate3_vote,
    output logic [TALLY_W-1:0]        candidate4_vote
);

    localparam int unsigned CNT_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t r_state, w_state_d;

    logic [NUM_CANDIDATES-1:0] w_btn_s;
    logic [NUM_CANDIDATES-1:0] w_press;
    logic [NUM_CANDIDATES-1:0] r_cap;
    logic [CNT_W-1:0]          r_cnt;
    logic [TALLY_W-1:0]        r_tally [NUM_CANDIDATES];
    logic                      r_en_q;
    logic                      r_reject;
    logic                      w_en_rise;
    logic                      w_single;
    logic                      w_cnt_done;
    logic                      w_reject_d;

    button_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NUM_CANDIDATES)
    ) u_button_sync (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (candidate_button),
        .o_btn_s (w_btn_s),
        .o_press (w_press)
    );

    assign w_en_rise  = ballot_enable & ~r_en_q;
    assign w_single   = (count_ones(w_press) == 1);
    assign w_cnt_done = (r_cnt >= CNT_LAST);
    // A press rejects unless it becomes a vote; result-mode browsing is silent.
    assign w_reject_d = !mode && (w_press != '0) && !(r_state == StArmed && w_single);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (!mode && w_en_rise) begin
                    w_state_d = StArmed;
                end
            end
            StArmed: begin
                if (mode) begin
                    w_state_d = StIdle;
                end else if (w_single) begin
                    w_state_d = StCommit;
                end
            end
            StCommit: begin
                w_state_d = StLockout;
            end
            StLockout: begin
                if (w_cnt_done && (w_btn_s == '0)) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        armed             = (r_state == StArmed);
        valid_vote_casted = (r_state == StCommit);
        vote_onehot       = valid_vote_casted ? r_cap : '0;
        reject_pulse      = r_reject;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en_q   <= 1'b0;
            r_reject <= 1'b0;
            r_cap    <= '0;
            r_cnt    <= '0;
        end else begin
            r_en_q   <= ballot_enable;
            r_reject <= w_reject_d;
            if (r_state == StArmed && !mode && w_single) begin
                r_cap <= w_press;
            end
            if (r_state != StLockout) begin
                r_cnt <= '0;
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Tally bumps on the edge leaving COMMIT, so a reset during COMMIT drops the vote.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                r_tally[i] <= '0;
            end
        end else if (r_state == StCommit) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                if (r_cap[i] && (r_tally[i] != '1)) begin
                    r_tally[i] <= r_tally[i] + TALLY_W'(1);
                end
            end
        end
    end

    assign candidate1_vote = r_tally[0];
    assign candidate2_vote = r_tally[1];
    assign candidate3_vote = r_tally[2];
    assign candidate4_vote = r_tally[3];

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with a vote scoreboard and immediate-assertion checks.
module tb_ballot_controller;

    localparam int unsigned LOCK = 10;
    localparam int unsigned SYNC = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic       ballot_enable;
    logic [3:0] candidate_button;
    logic       armed;
    logic       valid_vote_casted;
    logic [3:0] vote_onehot;
    logic       reject_pulse;
    logic [7:0] candidate1_vote;
    logic [7:0] candidate2_vote;
    logic [7:0] candidate3_vote;
    logic [7:0] candidate4_vote;

    int         n_checks = 0;
    int         n_err    = 0;
    int         rej_cnt  = 0;
    int         rej_base = 0;
    int         obs_rd   = 0;
    logic [3:0] exp_q [$];
    logic [3:0] obs_q [$];

    ballot_controller #(
        .LOCKOUT_CYCLES (LOCK),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .ballot_enable     (ballot_enable),
        .candidate_button  (candidate_button),
        .armed             (armed),
        .valid_vote_casted (valid_vote_casted),
        .vote_onehot       (vote_onehot),
        .reject_pulse      (reject_pulse),
        .candidate1_vote   (candidate1_vote),
        .candidate2_vote   (candidate2_vote),
        .candidate3_vote   (candidate3_vote),
        .candidate4_vote   (candidate4_vote)
    );

    always #5 clock = ~clock;

    // Every cycle of valid_vote_casted lands in obs_q, so a stretched pulse shows as an extra vote.
    always @(negedge clock) begin
        if (valid_vote_casted) obs_q.push_back(vote_onehot);
        if (reject_pulse) rej_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tallies(input string tag, input int e1, input int e2,
                                 input int e3, input int e4);
        check({tag, "_c1"}, 32'(candidate1_vote), 32'(e1));
        check({tag, "_c2"}, 32'(candidate2_vote), 32'(e2));
        check({tag, "_c3"}, 32'(candidate3_vote), 32'(e3));
        check({tag, "_c4"}, 32'(candidate4_vote), 32'(e4));
    endtask

    task automatic sb_check(input string tag);
        int         n_obs;
        logic [3:0] e;
        logic [3:0] o;
        n_obs = obs_q.size() - obs_rd;
        check({tag, "_nvotes"}, 32'(n_obs), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 4'bxxxx;
            obs_rd++;
            check({tag, "_vote"}, 32'(o), 32'(e));
        end
        obs_rd = obs_q.size();
    endtask

    task automatic arm();
        ballot_enable = 1'b1;
        tick(1);
        ballot_enable = 1'b0;
        tick(1);
    endtask

    initial begin
        reset            = 1'b1;
        mode             = 1'b0;
        ballot_enable    = 1'b0;
        candidate_button = 4'b0000;
        #1;
        check("rst_armed", 32'(armed), 0);
        check("rst_valid", 32'(valid_vote_casted), 0);
        check("rst_onehot", 32'(vote_onehot), 0);
        check("rst_reject", 32'(reject_pulse), 0);
        check_tallies("rst", 0, 0, 0, 0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // Single vote for candidate 2 with exact latency.
        rej_base = rej_cnt;
        arm();
        check("v2_armed", 32'(armed), 1);
        candidate_button = 4'b0010;
        exp_q.push_back(4'b0010);
        tick(SYNC + 2);
        check("v2_lat_valid", 32'(valid_vote_casted), 1);
        check("v2_lat_onehot", 32'(vote_onehot), 32'h2);
        check("v2_tally_pre", 32'(candidate2_vote), 0);
        tick(1);
        check("v2_valid_drop", 32'(valid_vote_casted), 0);
        check("v2_onehot_drop", 32'(vote_onehot), 0);
        check("v2_tally_post", 32'(candidate2_vote), 1);
        candidate_button = 4'b0000;
        tick(20);
        sb_check("v2");
        check_tallies("v2", 0, 1, 0, 0);
        check("v2_rejects", 32'(rej_cnt - rej_base), 0);

        // Double press rejected, armed kept, then a clean vote for candidate 3.
        rej_base = rej_cnt;
        arm();
        candidate_button = 4'b0101;
        tick(3);
        candidate_button = 4'b0000;
        tick(8);
        check("dbl_rejects", 32'(rej_cnt - rej_base), 1);
        check("dbl_armed", 32'(armed), 1);
        sb_check("dbl");
        candidate_button = 4'b0100;
        exp_q.push_back(4'b0100);
        tick(3);
        candidate_button = 4'b0000;
        tick(20);
        sb_check("v3");
        check_tallies("v3", 0, 1, 1, 0);

        // Unarmed press rejected; arm twice only grants one vote.
        rej_base = rej_cnt;
        candidate_button = 4'b1000;
        tick(3);
        candidate_button = 4'b0000;
        tick(8);
        check("idle_rejects", 32'(rej_cnt - rej_base), 1);
        check_tallies("idle", 0, 1, 1, 0);
        arm();
        arm();
        candidate_button = 4'b0001;
        exp_q.push_back(4'b0001);
        tick(3);
        candidate_button = 4'b0000;
        tick(20);
        rej_base = rej_cnt;
        candidate_button = 4'b0001;
        tick(3);
        candidate_button = 4'b0000;
        tick(8);
        check("twice_rejects", 32'(rej_cnt - rej_base), 1);
        sb_check("twice");
        check_tallies("twice", 1, 1, 1, 0);

        // Button held past lockout keeps the controller locked until release.
        rej_base = rej_cnt;
        arm();
        candidate_button = 4'b0001;
        exp_q.push_back(4'b0001);
        tick(30);
        arm();
        check("hold_locked", 32'(armed), 0);
        candidate_button = 4'b0000;
        tick(5);
        arm();
        check("hold_rearm", 32'(armed), 1);
        candidate_button = 4'b0010;
        exp_q.push_back(4'b0010);
        tick(3);
        candidate_button = 4'b0000;
        tick(20);
        sb_check("hold");
        check_tallies("hold", 2, 2, 1, 0);
        check("hold_rejects", 32'(rej_cnt - rej_base), 0);

        // Drive candidate 1 to saturation, then one more vote.
        for (int i = 0; i < 253; i++) begin
            arm();
            candidate_button = 4'b0001;
            exp_q.push_back(4'b0001);
            tick(2);
            candidate_button = 4'b0000;
            tick(18);
        end
        check("sat_reach", 32'(candidate1_vote), 255);
        arm();
        candidate_button = 4'b0001;
        exp_q.push_back(4'b0001);
        tick(2);
        candidate_button = 4'b0000;
        tick(18);
        sb_check("sat");
        check_tallies("sat", 255, 2, 1, 0);

        // Result mode disarms and suppresses rejects and tally changes.
        rej_base = rej_cnt;
        arm();
        mode = 1'b1;
        tick(1);
        check("mode_disarm", 32'(armed), 0);
        candidate_button = 4'b0010;
        tick(3);
        candidate_button = 4'b0000;
        tick(8);
        check("mode_rejects", 32'(rej_cnt - rej_base), 0);
        mode = 1'b0;
        tick(2);
        check("mode_armed", 32'(armed), 0);
        sb_check("mode");
        check_tallies("mode", 255, 2, 1, 0);

        // Reset in COMMIT discards the vote; the held button registers afterwards.
        arm();
        candidate_button = 4'b1000;
        exp_q.push_back(4'b1000);
        tick(SYNC + 2);
        check("rc_commit", 32'(valid_vote_casted), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rc_valid", 32'(valid_vote_casted), 0);
        check("rc_onehot", 32'(vote_onehot), 0);
        check("rc_armed", 32'(armed), 0);
        check("rc_reject", 32'(reject_pulse), 0);
        check_tallies("rc", 0, 0, 0, 0);
        tick(3);
        rej_base = rej_cnt;
        reset = 1'b0;
        tick(8);
        check("rc_held_press", 32'(rej_cnt - rej_base), 1);
        check_tallies("rc_after", 0, 0, 0, 0);
        sb_check("rc");
        candidate_button = 4'b0000;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
